// File: rtl/sram_arbiter.sv
// Two-port arbiter and word sequencer for the shared external SRAM.
// Grants port A or B round-robin on ties and runs an auto-incrementing read/write burst.
module sram_arbiter #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_a,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [LEN_W-1:0]  len_a,
   input  logic [DATA_W-1:0] wdata_a,
   input  logic              req_b,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [LEN_W-1:0]  len_b,
   input  logic [DATA_W-1:0] wdata_b,
   output logic              grant_a,
   output logic              grant_b,
   output logic              xfer_a,
   output logic              xfer_b,
   output logic              done_a,
   output logic              done_b,
   output logic              busy,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_dout,
   input  logic [DATA_W-1:0] sram_din,
   output logic              DE,
   output logic              nWE,
   output logic              nOE,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid
);

   // state     | meaning
   // IDLE      | no owner; arbitrate req_a/req_b
   // W_SETUP   | address/data set up, DE on, word strobe to requester
   // W_PULSE   | nWE low
   // W_HOLD    | data held, nWE high; advance address/count on exit
   // R_SETUP   | nOE low, address settling (also the post-sample word cycle)
   // R_SAMPLE  | nOE low; sram_din captured on exit
   // DONE      | one-cycle done pulse, strobes inactive
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_W_SETUP  = 3'd1,
      S_W_PULSE  = 3'd2,
      S_W_HOLD   = 3'd3,
      S_R_SETUP  = 3'd4,
      S_R_SAMPLE = 3'd5,
      S_DONE     = 3'd6
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_sel_b;
   logic                r_rr_last_b;
   logic [LEN_W-1:0]    r_remaining;
   logic [ADDR_W-1:0]   r_sram_addr;
   logic [DATA_W-1:0]   r_sram_dout;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_rdata_valid;
   logic                r_grant_a;
   logic                r_grant_b;
   logic                r_xfer_a;
   logic                r_xfer_b;
   logic                r_done_a;
   logic                r_done_b;
   logic                r_busy;
   logic                r_de;
   logic                r_nwe;
   logic                r_noe;

   logic                w_win_b;
   logic                w_grant;
   logic                w_we_sel;
   logic [LEN_W-1:0]    w_len_sel;
   logic [ADDR_W-1:0]   w_addr_sel;
   logic                w_last;
   logic                w_port_b;

   logic                w_grant_a_nxt;
   logic                w_grant_b_nxt;
   logic                w_xfer_a_nxt;
   logic                w_xfer_b_nxt;
   logic                w_done_a_nxt;
   logic                w_done_b_nxt;
   logic                w_busy_nxt;
   logic                w_de_nxt;
   logic                w_nwe_nxt;
   logic                w_noe_nxt;
   logic                w_rvalid_nxt;

   // On a tie the port that did not win last time is granted.
   assign w_win_b    = req_b & ~(req_a & r_rr_last_b);
   assign w_we_sel   = w_win_b ? we_b   : we_a;
   assign w_len_sel  = w_win_b ? len_b  : len_a;
   assign w_addr_sel = w_win_b ? addr_b : addr_a;
   assign w_last     = (r_remaining == LEN_W'(1));
   assign w_port_b   = (r_state == S_IDLE) ? w_win_b : r_sel_b;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req_a || req_b) begin
               w_grant = 1'b1;
               if (w_len_sel == '0) begin
                  w_state_nxt = S_DONE;
               end else if (w_we_sel) begin
                  w_state_nxt = S_W_SETUP;
               end else begin
                  w_state_nxt = S_R_SETUP;
               end
            end
         end
         S_W_SETUP:  w_state_nxt = S_W_PULSE;
         S_W_PULSE:  w_state_nxt = S_W_HOLD;
         S_W_HOLD:   w_state_nxt = w_last ? S_DONE : S_W_SETUP;
         S_R_SETUP:  w_state_nxt = S_R_SAMPLE;
         S_R_SAMPLE: w_state_nxt = w_last ? S_DONE : S_R_SETUP;
         S_DONE:     w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs are computed from the next state and registered, so every pin is a flop.
   always_comb begin
      w_busy_nxt    = (w_state_nxt != S_IDLE);
      w_grant_a_nxt = w_busy_nxt & ~w_port_b;
      w_grant_b_nxt = w_busy_nxt &  w_port_b;
      w_de_nxt      = (w_state_nxt == S_W_SETUP) || (w_state_nxt == S_W_PULSE) ||
                      (w_state_nxt == S_W_HOLD);
      w_nwe_nxt     = (w_state_nxt != S_W_PULSE);
      w_noe_nxt     = !((w_state_nxt == S_R_SETUP) || (w_state_nxt == S_R_SAMPLE));
      w_rvalid_nxt  = (r_state == S_R_SAMPLE);
      w_xfer_a_nxt  = ((w_state_nxt == S_W_SETUP) || w_rvalid_nxt) & ~w_port_b;
      w_xfer_b_nxt  = ((w_state_nxt == S_W_SETUP) || w_rvalid_nxt) &  w_port_b;
      w_done_a_nxt  = (w_state_nxt == S_DONE) & ~w_port_b;
      w_done_b_nxt  = (w_state_nxt == S_DONE) &  w_port_b;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sel_b       <= 1'b0;
         r_rr_last_b   <= 1'b1;
         r_remaining   <= '0;
         r_sram_addr   <= '0;
         r_sram_dout   <= '0;
         r_rdata       <= '0;
         r_rdata_valid <= 1'b0;
         r_grant_a     <= 1'b0;
         r_grant_b     <= 1'b0;
         r_xfer_a      <= 1'b0;
         r_xfer_b      <= 1'b0;
         r_done_a      <= 1'b0;
         r_done_b      <= 1'b0;
         r_busy        <= 1'b0;
         r_de          <= 1'b0;
         r_nwe         <= 1'b1;
         r_noe         <= 1'b1;
      end else begin
         if (w_grant) begin
            r_sel_b     <= w_win_b;
            r_rr_last_b <= w_win_b;
            r_sram_addr <= w_addr_sel;
            r_remaining <= w_len_sel;
         end else if ((r_state == S_W_HOLD) || (r_state == S_R_SAMPLE)) begin
            r_remaining <= r_remaining - LEN_W'(1);
            r_sram_addr <= r_sram_addr + ADDR_W'(1);
         end
         if (r_state == S_R_SAMPLE) begin
            r_rdata <= sram_din;
         end
         if (w_state_nxt == S_W_SETUP) begin
            r_sram_dout <= w_port_b ? wdata_b : wdata_a;
         end
         r_rdata_valid <= w_rvalid_nxt;
         r_grant_a     <= w_grant_a_nxt;
         r_grant_b     <= w_grant_b_nxt;
         r_xfer_a      <= w_xfer_a_nxt;
         r_xfer_b      <= w_xfer_b_nxt;
         r_done_a      <= w_done_a_nxt;
         r_done_b      <= w_done_b_nxt;
         r_busy        <= w_busy_nxt;
         r_de          <= w_de_nxt;
         r_nwe         <= w_nwe_nxt;
         r_noe         <= w_noe_nxt;
      end
   end

   assign grant_a     = r_grant_a;
   assign grant_b     = r_grant_b;
   assign xfer_a      = r_xfer_a;
   assign xfer_b      = r_xfer_b;
   assign done_a      = r_done_a;
   assign done_b      = r_done_b;
   assign busy        = r_busy;
   assign sram_addr   = r_sram_addr;
   assign sram_dout   = r_sram_dout;
   assign DE          = r_de;
   assign nWE         = r_nwe;
   assign nOE         = r_noe;
   assign rdata       = r_rdata;
   assign rdata_valid = r_rdata_valid;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: a burst-level model predicts SRAM writes,
// read data and done timing; a negedge monitor pops and compares.
module tb_sram_arbiter;

   logic        clk;
   logic        reset;
   logic        req_a, we_a, req_b, we_b;
   logic [10:0] addr_a, addr_b;
   logic [3:0]  len_a, len_b;
   logic [7:0]  wdata_a, wdata_b;
   logic        grant_a, grant_b, xfer_a, xfer_b, done_a, done_b, busy;
   logic [10:0] sram_addr;
   logic [7:0]  sram_dout, sram_din, rdata;
   logic        DE, nWE, nOE, rdata_valid;

   sram_arbiter #(.ADDR_W(11), .DATA_W(8), .LEN_W(4)) dut (
      .clk(clk), .reset(reset),
      .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .len_a(len_a), .wdata_a(wdata_a),
      .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .len_b(len_b), .wdata_b(wdata_b),
      .grant_a(grant_a), .grant_b(grant_b), .xfer_a(xfer_a), .xfer_b(xfer_b),
      .done_a(done_a), .done_b(done_b), .busy(busy),
      .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
      .DE(DE), .nWE(nWE), .nOE(nOE), .rdata(rdata), .rdata_valid(rdata_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // SRAM device model
   logic [7:0] mem [2048];
   assign sram_din = mem[sram_addr];
   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = i[7:0];
      forever begin
         @(posedge clk);
         if (!nWE) mem[sram_addr] <= sram_dout;
      end
   end

   typedef struct { logic [10:0] a; logic [7:0] d; } wr_t;
   typedef struct { bit pb; int lat; int nwe; int noe; int de; } done_t;

   wr_t         exp_wr[$];
   logic [7:0]  exp_rd[$];
   done_t       exp_done[$];
   logic [7:0]  ref_mem [2048];
   logic [7:0]  dat_a [16];
   logic [7:0]  dat_b [16];
   bit          rr_b;
   bit          mon_off;
   int          n_checks;
   int          n_pass;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Burst-level reference: what the SRAM and requester must see for one grant.
   task automatic predict(input bit pb);
      logic [10:0] a;
      int          n;
      bit          w;
      done_t       e;
      a = pb ? addr_b : addr_a;
      n = int'(pb ? len_b : len_a);
      w = pb ? we_b : we_a;
      for (int i = 0; i < n; i++) begin
         if (w) begin
            wr_t x;
            x.a = a;
            x.d = pb ? dat_b[i] : dat_a[i];
            exp_wr.push_back(x);
            ref_mem[a] = x.d;
         end else begin
            exp_rd.push_back(ref_mem[a]);
         end
         a = a + 11'd1;
      end
      e.pb  = pb;
      e.lat = w ? 3 * n : 2 * n;
      e.nwe = w ? n : 0;
      e.noe = w ? 0 : 2 * n;
      e.de  = w ? 3 * n : 0;
      exp_done.push_back(e);
   endtask

   task automatic setup_port(input bit pb, input bit w, input logic [10:0] a, input logic [3:0] n);
      for (int i = 0; i < 16; i++) begin
         if (pb) dat_b[i] = 8'($urandom_range(0, 255));
         else    dat_a[i] = 8'($urandom_range(0, 255));
      end
      if (pb) begin we_b = w; addr_b = a; len_b = n; wdata_b = dat_b[0]; end
      else    begin we_a = w; addr_a = a; len_a = n; wdata_a = dat_a[0]; end
   endtask

   task automatic run_port(input bit pb);
      int k;
      bit got;
      k = 0;
      got = 1'b0;
      if (pb) req_b = 1'b1; else req_a = 1'b1;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk);
         if (pb ? xfer_b : xfer_a) begin
            k++;
            if (pb) wdata_b = dat_b[k % 16]; else wdata_a = dat_a[k % 16];
         end
         if (pb ? done_b : done_a) got = 1'b1;
      end
      chk(pb ? "done_b_timeout" : "done_a_timeout", got, 1);
      if (pb) req_b = 1'b0; else req_a = 1'b0;
   endtask

   task automatic run_single(input bit pb);
      predict(pb);
      rr_b = pb;
      run_port(pb);
   endtask

   task automatic run_pair();
      bit first;
      first = rr_b ? 1'b0 : 1'b1;
      predict(first);
      predict(~first);
      rr_b = ~first;
      fork
         run_port(1'b0);
         run_port(1'b1);
      join
   endtask

   // Monitor
   int  cyc, gcyc, c_nwe, c_noe, c_de;
   bit  prev_g;
   initial begin
      cyc = 0; gcyc = 0; c_nwe = 0; c_noe = 0; c_de = 0; prev_g = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         chk("strobe_excl", ((!nWE && !nOE) || (DE && !nOE)) ? 1 : 0, 0);
         chk("grant_onehot", (grant_a && grant_b) ? 1 : 0, 0);
         if (!mon_off) begin
            if ((grant_a || grant_b) && !prev_g) begin
               gcyc = cyc; c_nwe = 0; c_noe = 0; c_de = 0;
            end
            if (!nWE) c_nwe++;
            if (!nOE) c_noe++;
            if (DE)   c_de++;
            if (!nWE) begin
               if (exp_wr.size() == 0) chk("write_unexpected", 1, 0);
               else begin
                  wr_t x;
                  x = exp_wr.pop_front();
                  chk("write_addr", sram_addr, x.a);
                  chk("write_data", sram_dout, x.d);
               end
            end
            if (rdata_valid) begin
               chk("rvalid_xfer", grant_a ? xfer_a : xfer_b, 1);
               if (exp_rd.size() == 0) chk("read_unexpected", 1, 0);
               else chk("read_data", rdata, exp_rd.pop_front());
            end
            if (done_a || done_b) begin
               if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
               else begin
                  done_t e;
                  e = exp_done.pop_front();
                  chk("done_port", done_b, e.pb);
                  chk("done_grant", done_b ? grant_b : grant_a, 1);
                  chk("done_latency", cyc - gcyc, e.lat);
                  chk("nwe_low_cycles", c_nwe, e.nwe);
                  chk("noe_low_cycles", c_noe, e.noe);
                  chk("de_cycles", c_de, e.de);
               end
            end
         end
         prev_g = grant_a || grant_b;
      end
   end

   initial begin
      bit found;
      n_checks = 0; n_pass = 0; mon_off = 1'b1; rr_b = 1'b1;
      for (int i = 0; i < 2048; i++) ref_mem[i] = i[7:0];
      reset = 1'b0;
      req_a = 0; we_a = 0; addr_a = '0; len_a = '0; wdata_a = '0;
      req_b = 0; we_b = 0; addr_b = '0; len_b = '0; wdata_b = '0;
      repeat (3) @(negedge clk);
      chk("rst_strobes", {nWE, nOE, DE}, 3'b110);
      chk("rst_ctrl", {busy, grant_a, grant_b, xfer_a, xfer_b, done_a, done_b, rdata_valid}, 0);
      chk("rst_sram_addr", sram_addr, 0);
      chk("rst_sram_dout", sram_dout, 0);
      chk("rst_rdata", rdata, 0);
      reset = 1'b1;
      @(negedge clk);
      mon_off = 1'b0;

      // Single write burst from A
      setup_port(1'b0, 1'b1, 11'h010, 4'd2);
      dat_a[0] = 8'hA5; dat_a[1] = 8'h5A; wdata_a = 8'hA5;
      run_single(1'b0);

      // Read burst from B across the address wrap
      setup_port(1'b1, 1'b0, 11'h7FE, 4'd3);
      run_single(1'b1);

      // Simultaneous one-word writes, twice
      repeat (2) begin
         setup_port(1'b0, 1'b1, 11'($urandom_range(0, 2047)), 4'd1);
         setup_port(1'b1, 1'b1, 11'($urandom_range(0, 2047)), 4'd1);
         run_pair();
      end

      // Zero-length burst
      setup_port(1'b0, 1'b0, 11'h123, 4'd0);
      run_single(1'b0);

      // Reset during the write pulse
      @(negedge clk);
      mon_off = 1'b1;
      setup_port(1'b0, 1'b1, 11'h100, 4'd4);
      req_a = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 30 && !found; c++) begin
         @(negedge clk);
         if (!nWE) found = 1'b1;
      end
      chk("rst_reach_pulse", found, 1);
      reset = 1'b0;
      req_a = 1'b0;
      @(negedge clk);
      chk("midrst_strobes", {nWE, nOE, DE}, 3'b110);
      chk("midrst_ctrl", {busy, grant_a, done_a}, 0);
      @(negedge clk);
      chk("midrst_no_done", done_a, 0);
      reset = 1'b1;
      if (found) ref_mem[11'h100] = dat_a[0];
      rr_b = 1'b1;
      @(negedge clk);
      mon_off = 1'b0;

      // Normal grant after reset, reading back the partially written word
      setup_port(1'b0, 1'b0, 11'h0FF, 4'd3);
      run_single(1'b0);

      // Randomized mix
      for (int it = 0; it < 40; it++) begin
         int mode;
         mode = $urandom_range(0, 2);
         for (int p = 0; p < 2; p++) begin
            logic [10:0] a;
            a = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(2032, 2047))
                                             : 11'($urandom_range(0, 2047));
            setup_port(p[0], 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)));
         end
         if (mode == 2) run_pair();
         else run_single(mode[0]);
      end

      repeat (5) @(negedge clk);
      chk("exp_wr_empty", exp_wr.size(), 0);
      chk("exp_rd_empty", exp_rd.size(), 0);
      chk("exp_done_empty", exp_done.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
